mem_arbiter: RTL

Two-port arbiter and sequencer for the single-ported data memory (8-bit word address, 4-bit byte write enable, 32-bit data, synchronous read with one-cycle latency). It shares the memory between the instruction-fetch requester (read-only) and the load/store requester (read/write). It serialises accesses through a fixed three-state sequence and returns read data or write completion with a one-cycle acknowledge. Load/store normally has priority; a starvation guard bounds how long fetch can wait.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory: fetch (read-only)
// and load/store share the memory through a fixed IDLE -> ISSUE -> RESP sequence.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    input  logic [3:0]  ls_wstrb,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_en,
    output logic [7:0]  mem_addr,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        grant
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [7:0]  addr_q, addr_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [3:0]  starve_q, starve_d;
    logic        pick_ls;
    logic        rd_ok;

    // Byte offset within the word is the requester's concern.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], ls_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            addr_q   <= '0;
            wen_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        starve_d = starve_q;
        pick_ls  = ls_req && !(if_req && starve_q == LIMIT);
        unique case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    state_d = ISSUE;
                    grant_d = pick_ls;
                    if (pick_ls) begin
                        addr_d  = ls_addr[9:2];
                        wen_d   = ls_wstrb;
                        wdata_d = ls_wdata;
                        err_d   = |ls_addr[31:10];
                    end else begin
                        addr_d  = if_addr[9:2];
                        wen_d   = '0;
                        wdata_d = '0;
                        err_d   = |if_addr[31:10];
                    end
                    // Count only load/store wins that left fetch waiting.
                    if (pick_ls && if_req)
                        starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
                    else
                        starve_d = '0;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_ok = !err_q && (wen_q == 4'b0000);

    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_wen   = '0;
        mem_wdata = '0;
        if_ack    = 1'b0;
        if_rdata  = '0;
        if_err    = 1'b0;
        ls_ack    = 1'b0;
        ls_rdata  = '0;
        ls_err    = 1'b0;
        if (state_q == ISSUE) begin
            mem_en    = !err_q;
            mem_addr  = addr_q;
            mem_wen   = err_q ? 4'b0000 : wen_q;
            mem_wdata = wdata_q;
        end
        // Read data is taken straight from the memory in its valid cycle.
        if (state_q == RESP) begin
            if (grant_q) begin
                ls_ack   = 1'b1;
                ls_err   = err_q;
                ls_rdata = rd_ok ? mem_rdata : '0;
            end else begin
                if_ack   = 1'b1;
                if_err   = err_q;
                if_rdata = rd_ok ? mem_rdata : '0;
            end
        end
    end

    assign grant = grant_q;

endmodule
